// File: rtl/coord_bcd_converter_pkg.sv
// Shared types for the tracker display path: target coordinate, BCD digit buffer
// and the converter FSM encoding.
package coord_bcd_converter_pkg;

  localparam int PT_COORD_W           = 8;
  localparam int BCD_DIGITS_PER_COORD = 4;
  localparam int BCD_SCRATCH_W        = 4 * BCD_DIGITS_PER_COORD;

  typedef logic [3:0]       bcd_digit_t;
  typedef bcd_digit_t [7:0] bcd_buf_t;

  typedef struct packed {
    logic [PT_COORD_W-1:0] x;
    logic [PT_COORD_W-1:0] y;
  } pt2D;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

endpackage

// File: rtl/coord_bcd_converter_bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left
// by one with the incoming binary bit entering bit 0.
module bcd_dabble_step
  import coord_bcd_converter_pkg::*;
(
  input  logic [BCD_SCRATCH_W-1:0] i_scratch,
  input  logic                     i_bit,
  output logic [BCD_SCRATCH_W-1:0] o_scratch
);

  logic [BCD_SCRATCH_W-1:0] w_corr;

  // Nibbles are at most 9 on entry, so the 4-bit sum cannot wrap.
  function automatic bcd_digit_t add3(input bcd_digit_t d);
    return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
  endfunction

  always_comb begin
    w_corr = '0;
    for (int i = 0; i < BCD_DIGITS_PER_COORD; i++) begin
      w_corr[4*i +: 4] = add3(i_scratch[4*i +: 4]);
    end
    o_scratch = {w_corr[BCD_SCRATCH_W-2:0], i_bit};
  end

endmodule

// File: rtl/coord_bcd_converter.sv
// Sequential binary-to-BCD converter feeding the 7-segment tracker; x and y are
// converted in parallel, one bit per cycle, and committed atomically.
module coord_bcd_converter
  import coord_bcd_converter_pkg::*;
#(
  parameter int COORD_W = PT_COORD_W
) (
  input  logic     clk,
  input  logic     rst,
  input  pt2D      target,
  output bcd_buf_t digits,
  output logic     valid,
  output logic     busy
);

  localparam int CNT_W = $clog2(COORD_W + 1);

  conv_state_e              r_state;
  conv_state_e              w_state_nxt;
  pt2D                      r_src;
  pt2D                      r_last_conv;
  logic [COORD_W-1:0]       r_sh_x;
  logic [COORD_W-1:0]       r_sh_y;
  logic [BCD_SCRATCH_W-1:0] r_scr_x;
  logic [BCD_SCRATCH_W-1:0] r_scr_y;
  logic [BCD_SCRATCH_W-1:0] w_scr_x_nxt;
  logic [BCD_SCRATCH_W-1:0] w_scr_y_nxt;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_force;
  bcd_buf_t                 r_digits;
  logic                     r_valid;
  logic                     w_start;
  logic                     w_last_shift;

  assign w_start      = r_force || (target != r_last_conv);
  assign w_last_shift = (r_cnt == CNT_W'(COORD_W - 1));

  bcd_dabble_step u_step_x (
    .i_scratch (r_scr_x),
    .i_bit     (r_sh_x[COORD_W-1]),
    .o_scratch (w_scr_x_nxt)
  );

  bcd_dabble_step u_step_y (
    .i_scratch (r_scr_y),
    .i_bit     (r_sh_y[COORD_W-1]),
    .o_scratch (w_scr_y_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_start) w_state_nxt = ST_SHIFT;
      ST_SHIFT:  if (w_last_shift) w_state_nxt = ST_COMMIT;
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (r_state != ST_IDLE);
    digits = r_digits;
    valid  = r_valid;
  end

  // Scratch, shifters and counter need no reset: IDLE reloads them before use.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_digits    <= '0;
      r_valid     <= 1'b0;
      r_last_conv <= '0;
      r_force     <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_src   <= target;
            r_sh_x  <= target.x;
            r_sh_y  <= target.y;
            r_scr_x <= '0;
            r_scr_y <= '0;
            r_cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          r_scr_x <= w_scr_x_nxt;
          r_scr_y <= w_scr_y_nxt;
          r_sh_x  <= r_sh_x << 1;
          r_sh_y  <= r_sh_y << 1;
          r_cnt   <= r_cnt + 1'b1;
        end
        ST_COMMIT: begin
          r_digits    <= {r_scr_y, r_scr_x};
          r_valid     <= 1'b1;
          r_last_conv <= r_src;
          r_force     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
